// File: rtl/zero2one_stream_average.sv
// Streaming per-lane averager: accumulates zero2one vectors into saturating fractions
// and emits the per-lane mean once a batch closes (N samples or in_last_i).
module zero2one_stream_average #(
  parameter  int unsigned N   = 16,
  parameter  int unsigned LEN = 32,
  localparam int unsigned ZW  = 16,
  localparam int unsigned CW  = $clog2(N + 1)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  input  logic [ZW-1:0] in_data_i [LEN],
  input  logic          in_last_i,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic [ZW-1:0] out_data_o [LEN],
  output logic [CW-1:0] out_count_o
);
  // zero2one_t: unsigned, 15 fractional bits, 1.0 == 0x8000 is the largest legal value.
  // frac_t: signed, same binary point, wide enough that saturation is a safety net only.
  localparam int unsigned ZF = 15;
  localparam int unsigned FW = 32;
  localparam logic [ZW-1:0]        Z2O_MAX   = ZW'(32'd1 << ZF);
  localparam logic signed [FW-1:0] FRAC_ZERO = '0;
  localparam logic signed [FW-1:0] FRAC_MAX  = {1'b0, {(FW-1){1'b1}}};
  localparam logic signed [FW-1:0] FRAC_MIN  = {1'b1, {(FW-1){1'b0}}};

  typedef enum logic {S_ACCUM, S_OUT} state_e;

  function automatic logic signed [FW-1:0] zero2one_to_frac(input logic [ZW-1:0] z);
    return $signed(FW'(z));
  endfunction

  function automatic logic signed [FW-1:0] frac_add(input logic signed [FW-1:0] a,
                                                    input logic signed [FW-1:0] b);
    logic signed [FW-1:0] r;
    r = a + b;
    if ((a[FW-1] == b[FW-1]) && (r[FW-1] != a[FW-1])) r = a[FW-1] ? FRAC_MIN : FRAC_MAX;
    return r;
  endfunction

  function automatic logic signed [FW-1:0] frac_unsigned_div_int(input logic signed [FW-1:0] s,
                                                                 input logic [CW-1:0]        c);
    logic [FW-1:0] us;
    us = s;
    if (s < 0) return FRAC_ZERO;
    return $signed(us / FW'(c));
  endfunction

  function automatic logic [ZW-1:0] unsigned_frac_to_zero2one_overflow_as_max(
      input logic signed [FW-1:0] f);
    if (f < 0) return '0;
    if (f > $signed(FW'(Z2O_MAX))) return Z2O_MAX;
    return ZW'(f);
  endfunction

  state_e               state_q, state_d;
  logic signed [FW-1:0] sum_q [LEN];
  logic signed [FW-1:0] sum_d [LEN];
  logic signed [FW-1:0] nxt_sum [LEN];
  logic [CW-1:0]        count_q, count_d, nxt_cnt;
  logic [ZW-1:0]        out_data_q [LEN];
  logic [ZW-1:0]        out_data_d [LEN];
  logic [CW-1:0]        out_count_q, out_count_d;
  logic                 out_valid_q, out_valid_d;
  logic                 accept, close;

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= S_ACCUM;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_ACCUM: if (accept && close) state_d = S_OUT;
      S_OUT:   if (out_ready_i)     state_d = S_ACCUM;
      default: state_d = S_ACCUM;
    endcase
  end

  // FSM outputs
  always_comb begin
    in_ready_o = (state_q == S_ACCUM);
  end

  assign accept = in_valid_i && in_ready_o;

  // Accumulate / close / release datapath
  always_comb begin
    for (int i = 0; i < LEN; i++) begin
      nxt_sum[i] = frac_add(sum_q[i], zero2one_to_frac(in_data_i[i]));
    end
    nxt_cnt     = count_q + CW'(1);
    close       = in_last_i || (count_q == CW'(N - 1));
    sum_d       = sum_q;
    count_d     = count_q;
    out_data_d  = out_data_q;
    out_count_d = out_count_q;
    out_valid_d = out_valid_q;
    if (state_q == S_ACCUM) begin
      if (accept) begin
        if (close) begin
          for (int i = 0; i < LEN; i++) begin
            out_data_d[i] = unsigned_frac_to_zero2one_overflow_as_max(
                              frac_unsigned_div_int(nxt_sum[i], nxt_cnt));
          end
          out_count_d = nxt_cnt;
          out_valid_d = 1'b1;
        end else begin
          sum_d   = nxt_sum;
          count_d = nxt_cnt;
        end
      end
    end else if (out_ready_i) begin
      // Result consumed: clear the batch so the next accept starts fresh.
      out_valid_d = 1'b0;
      for (int i = 0; i < LEN; i++) sum_d[i] = FRAC_ZERO;
      count_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < LEN; i++) begin
        sum_q[i]      <= FRAC_ZERO;
        out_data_q[i] <= '0;
      end
      count_q     <= '0;
      out_count_q <= '0;
      out_valid_q <= 1'b0;
    end else begin
      sum_q       <= sum_d;
      count_q     <= count_d;
      out_data_q  <= out_data_d;
      out_count_q <= out_count_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_data_o  = out_data_q;
  assign out_count_o = out_count_q;
  assign out_valid_o = out_valid_q;

endmodule

// File: tb/tb_zero2one_stream_average.sv
// Bench for zero2one_stream_average: two instances (N=4 and N=16), a per-instance
// mean-of-samples reference model checked every cycle, plus hand-computed expectations.
module tb_zero2one_stream_average;
  localparam int unsigned LEN = 32;
  localparam int unsigned ZW  = 16;
  localparam int unsigned ONE = 32768;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          in_valid [2];
  logic          in_last  [2];
  logic          out_ready[2];
  logic          in_ready [2];
  logic          out_valid[2];
  logic [ZW-1:0] in_data  [2][LEN];
  logic [ZW-1:0] out_data [2][LEN];
  logic [2:0]    oc_a;
  logic [4:0]    oc_b;
  logic [ZW-1:0] vec [LEN];

  int checks = 0;
  int errors = 0;

  zero2one_stream_average #(.N(4), .LEN(LEN)) dut_a (
    .clk_i(clk), .rst_i(rst),
    .in_valid_i(in_valid[0]), .in_ready_o(in_ready[0]),
    .in_data_i(in_data[0]), .in_last_i(in_last[0]),
    .out_valid_o(out_valid[0]), .out_ready_i(out_ready[0]),
    .out_data_o(out_data[0]), .out_count_o(oc_a)
  );

  zero2one_stream_average #(.N(16), .LEN(LEN)) dut_b (
    .clk_i(clk), .rst_i(rst),
    .in_valid_i(in_valid[1]), .in_ready_o(in_ready[1]),
    .in_data_i(in_data[1]), .in_last_i(in_last[1]),
    .out_valid_o(out_valid[1]), .out_ready_i(out_ready[1]),
    .out_data_o(out_data[1]), .out_count_o(oc_b)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int cnt_of(input int s);
    return (s == 0) ? int'(oc_a) : int'(oc_b);
  endfunction

  // Reference model: sum raw samples per lane, mean = floor(sum/count) clamped to 1.0.
  for (genvar g = 0; g < 2; g++) begin : g_mon
    localparam int unsigned NG = (g == 0) ? 4 : 16;
    longint unsigned acc [LEN];
    longint unsigned exp_d [LEN];
    int unsigned     cnt;
    int unsigned     exp_c;
    bit              exp_ov;
    bit              armed = 1'b0;

    always @(negedge clk) begin
      if (armed) begin
        chk($sformatf("in_ready[%0d]", g), longint'(in_ready[g]), longint'(!exp_ov));
        chk($sformatf("out_valid[%0d]", g), longint'(out_valid[g]), longint'(exp_ov));
        if (exp_ov) begin
          chk($sformatf("out_count[%0d]", g), longint'(cnt_of(g)), longint'(exp_c));
          for (int i = 0; i < LEN; i++)
            chk($sformatf("out_data[%0d][%0d]", g, i), longint'(out_data[g][i]), longint'(exp_d[i]));
        end
      end
      if (rst) begin
        armed  = 1'b1;
        exp_ov = 1'b0;
        cnt    = 0;
        for (int i = 0; i < LEN; i++) acc[i] = 0;
      end else if (armed) begin
        if (exp_ov) begin
          if (out_ready[g]) begin
            exp_ov = 1'b0;
            cnt    = 0;
            for (int i = 0; i < LEN; i++) acc[i] = 0;
          end
        end else if (in_valid[g]) begin
          for (int i = 0; i < LEN; i++) acc[i] += longint'(in_data[g][i]);
          cnt++;
          if (in_last[g] || cnt == NG) begin
            exp_ov = 1'b1;
            exp_c  = cnt;
            for (int i = 0; i < LEN; i++) begin
              exp_d[i] = acc[i] / cnt;
              if (exp_d[i] > ONE) exp_d[i] = ONE;
            end
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_vec(input int s, input bit last);
    int n = 0;
    in_valid[s] = 1'b1;
    in_last[s]  = last;
    for (int i = 0; i < LEN; i++) in_data[s][i] = vec[i];
    @(negedge clk);
    while (!in_ready[s] && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready[s]) chk("accept_timeout", 0, 1);
    step();
    in_valid[s] = 1'b0;
    in_last[s]  = 1'b0;
  endtask

  task automatic send(input int s, input logic [ZW-1:0] v, input bit last);
    for (int i = 0; i < LEN; i++) vec[i] = v;
    send_vec(s, last);
  endtask

  task automatic wait_out(input int s);
    int n = 0;
    @(negedge clk);
    while (!out_valid[s] && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid[s]) chk("out_timeout", 0, 1);
  endtask

  task automatic drain(input int s);
    step();
    out_ready[s] = 1'b1;
    step();
    out_ready[s] = 1'b0;
  endtask

  task automatic expect_out(input int s, input int lane0, input int cnt, input string name);
    wait_out(s);
    chk({name, "_lane0"}, longint'(out_data[s][0]), longint'(lane0));
    chk({name, "_count"}, longint'(cnt_of(s)), longint'(cnt));
    drain(s);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    for (int s = 0; s < 2; s++) begin
      in_valid[s] = 1'b0; in_last[s] = 1'b0; out_ready[s] = 1'b0;
      for (int i = 0; i < LEN; i++) in_data[s][i] = '0;
    end
    repeat (3) step();
    rst = 1'b0;
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      chk("rst_out_valid", longint'(out_valid[s]), 0);
      chk("rst_in_ready", longint'(in_ready[s]), 1);
      chk("rst_out_count", longint'(cnt_of(s)), 0);
      chk("rst_out_data0", longint'(out_data[s][0]), 0);
    end
    step();

    // Forced close at N=4: 0.25, 0.5, 0.75, 1.0 -> 0.625
    send(0, 16'd8192, 1'b0);
    send(0, 16'd16384, 1'b0);
    send(0, 16'd24576, 1'b0);
    send(0, 16'd32768, 1'b0);
    expect_out(0, 20480, 4, "t1_forced");

    // Early close: 0.2, 0.4 with in_last -> 0.3
    send(0, 16'd6554, 1'b0);
    send(0, 16'd13107, 1'b1);
    expect_out(0, 9830, 2, "t2_last");

    // Stall in OUT with a sample pending on the input
    send(0, 16'd1000, 1'b0);
    send(0, 16'd3000, 1'b1);
    wait_out(0);
    step();
    for (int i = 0; i < LEN; i++) vec[i] = 16'd30000;
    in_valid[0] = 1'b1;
    for (int i = 0; i < LEN; i++) in_data[0][i] = vec[i];
    repeat (5) step();
    in_valid[0] = 1'b0;
    @(negedge clk);
    chk("t3_stall_lane0", longint'(out_data[0][0]), 2000);
    chk("t3_stall_count", longint'(oc_a), 2);
    drain(0);

    // in_last at count==N-1 matches the forced close
    send(0, 16'd100, 1'b0);
    send(0, 16'd200, 1'b0);
    send(0, 16'd300, 1'b0);
    send(0, 16'd400, 1'b1);
    expect_out(0, 250, 4, "t_last_at_n");

    // Reset mid-batch discards the partial sums
    send(0, 16'd0, 1'b0);
    send(0, 16'd0, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) send(0, 16'd32768, 1'b0);
    expect_out(0, 32768, 4, "t4_after_rst");

    // Reset while a result is pending in OUT
    send(0, 16'd500, 1'b1);
    wait_out(0);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("t4_rst_in_out_valid", longint'(out_valid[0]), 0);
    chk("t4_rst_in_out_count", longint'(oc_a), 0);
    step();

    // N=16 saturation/clamp and single-sample batch
    for (int k = 0; k < 16; k++) send(1, 16'd32768, 1'b0);
    expect_out(1, 32768, 16, "t5_full_one");
    for (int k = 0; k < 16; k++) send(1, 16'hFFFF, 1'b0);
    expect_out(1, 32768, 16, "t5_clamp");
    send(1, 16'd16384, 1'b1);
    expect_out(1, 16384, 1, "t5_single");

    // Random batches with input gaps and output stalls
    for (int b = 0; b < 100; b++) begin
      int len;
      len = int'($urandom_range(1, 4));
      for (int k = 0; k < len; k++) begin
        repeat ($urandom_range(0, 2)) step();
        for (int i = 0; i < LEN; i++)
          vec[i] = ($urandom_range(0, 7) == 0) ? ZW'($urandom) : ZW'($urandom_range(0, ONE));
        send_vec(0, (k == len - 1) && (len < 4 || $urandom_range(0, 1) == 1));
      end
      wait_out(0);
      repeat ($urandom_range(0, 3)) step();
      drain(0);
    end

    repeat (3) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
